// File: rtl/adc_frame_streamer_pkg.sv
// ---------------------------------------------------------------------------
// adc_frame_streamer_pkg
// Shared definitions for the ADC capture-and-stream engine: the state
// encoding used by the top-level FSM, the default frame start byte, and the
// helper functions that size the sample path and the buffer index.
// No ports; imported by adc_frame_streamer and its sample buffer.
// ---------------------------------------------------------------------------
package adc_frame_streamer_pkg;

   typedef enum logic [3:0] {
      IDLE,
      CAPTURE,
      HDR,
      LEN0,
      LEN1,
      DATA,
      CSUM,
      WAIT_HI,
      WAIT_LO,
      DONE
   } state_e;

   localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;

   // Samples up to 8 bits fit in one byte on the wire, wider ones take two.
   function automatic int calc_bps(input int sample_w);
      return (sample_w <= 8) ? 1 : 2;
   endfunction

   // Width of the buffer write/read index; never narrower than one bit.
   function automatic int calc_idx_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/adc_frame_streamer_sample_buffer.sv
// ---------------------------------------------------------------------------
// adc_frame_streamer_sample_buffer
// Simple dual-port RAM, DEPTH x SAMPLE_W, synchronous write and registered
// read. The read port re-reads rd_addr every cycle, so a new address is
// reflected on rd_data one cycle later.
// Ports:
//   sysclk   clock, rising edge
//   rst      synchronous active-high reset (clears only the read register)
//   wr_en    write strobe
//   wr_addr  write index
//   wr_data  sample to store
//   rd_addr  read index
//   rd_data  registered read data
// ---------------------------------------------------------------------------
module adc_frame_streamer_sample_buffer
   import adc_frame_streamer_pkg::*;
#(
   parameter int SAMPLE_W = 12,
   parameter int DEPTH    = 32,
   localparam int IW      = calc_idx_w(DEPTH)
) (
   input  logic                sysclk,
   input  logic                rst,
   input  logic                wr_en,
   input  logic [IW-1:0]       wr_addr,
   input  logic [SAMPLE_W-1:0] wr_data,
   input  logic [IW-1:0]       rd_addr,
   output logic [SAMPLE_W-1:0] rd_data
);

   logic [SAMPLE_W-1:0] mem_q [DEPTH];
   logic [SAMPLE_W-1:0] rd_data_d;
   logic [SAMPLE_W-1:0] rd_data_q;

   // Storage array. It is not reset: every frame overwrites all DEPTH
   // entries before any of them is read back out.
   always_ff @(posedge sysclk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   // Asynchronous lookup feeding the read register.
   always_comb begin
      rd_data_d = mem_q[rd_addr];
   end

   // Registered read port.
   always_ff @(posedge sysclk) begin
      if (rst) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/adc_frame_streamer.sv
// ---------------------------------------------------------------------------
// adc_frame_streamer
// Captures DEPTH samples on rising edges of the divider strobe, then sends
// them through an external uart as: HDR_BYTE, DEPTH[7:0], DEPTH[15:8],
// sample bytes (low then high), XOR checksum of everything after the header.
// Supports single-shot and continuous runs and aborts capture when start
// drops; a frame that has begun transmitting always completes.
// Ports:
//   sysclk    clock, rising edge
//   rst       synchronous active-high reset
//   start     level; arms and holds a capture run
//   mode      0 single-shot, 1 continuous (latched when leaving IDLE)
//   ad_clk    sample strobe from the divider
//   data_ad   ADC result, valid at an ad_clk rising edge
//   tx_data   byte to the uart
//   tx_start  one-cycle write pulse to the uart
//   tx_busy   uart busy
//   ready     frame complete
//   busy      high in every state except IDLE and DONE
// ---------------------------------------------------------------------------
module adc_frame_streamer
   import adc_frame_streamer_pkg::*;
#(
   parameter int         SAMPLE_W = 12,
   parameter int         DEPTH    = 32,
   parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEFAULT
) (
   input  logic                sysclk,
   input  logic                rst,
   input  logic                start,
   input  logic                mode,
   input  logic                ad_clk,
   input  logic [SAMPLE_W-1:0] data_ad,
   output logic [7:0]          tx_data,
   output logic                tx_start,
   input  logic                tx_busy,
   output logic                ready,
   output logic                busy
);

   localparam int          BPS = calc_bps(SAMPLE_W);
   localparam int          IW  = calc_idx_w(DEPTH);
   localparam logic [15:0] LEN = 16'(DEPTH);

   state_e        state_q, state_d;
   state_e        cur_q, cur_d;
   logic          mode_q, mode_d;
   logic          ad_clk_q, ad_clk_d;
   logic [IW-1:0] wr_idx_q, wr_idx_d;
   logic [IW-1:0] rd_idx_q, rd_idx_d;
   logic          byte_sel_q, byte_sel_d;
   logic [7:0]    csum_q, csum_d;
   logic [7:0]    tx_data_q, tx_data_d;
   logic          tx_start_q, tx_start_d;

   logic                strobe_edge;
   logic                buf_we;
   logic [SAMPLE_W-1:0] rd_data;
   logic [15:0]         sample_ext;
   logic [7:0]          sample_byte;

   adc_frame_streamer_sample_buffer #(
      .SAMPLE_W (SAMPLE_W),
      .DEPTH    (DEPTH)
   ) u_sample_buffer (
      .sysclk  (sysclk),
      .rst     (rst),
      .wr_en   (buf_we),
      .wr_addr (wr_idx_q),
      .wr_data (data_ad),
      .rd_addr (rd_idx_q),
      .rd_data (rd_data)
   );

   // The byte of the current sample selected by byte_sel, with bits above
   // SAMPLE_W forced to zero. rd_idx/byte_sel are advanced when a data byte
   // is launched, so by the time WAIT_LO exits the registered read already
   // holds the next sample.
   always_comb begin
      sample_ext  = 16'(rd_data);
      sample_byte = byte_sel_q ? sample_ext[15:8] : sample_ext[7:0];
      strobe_edge = ad_clk && !ad_clk_q;
   end

   // Next-state and datapath logic. Each byte state launches its byte once
   // the uart is idle and remembers itself in cur so WAIT_LO knows which
   // byte comes next. tx_data is loaded on the transition into a byte state,
   // which keeps it stable from the cycle before tx_start until WAIT_LO ends.
   always_comb begin
      state_d    = state_q;
      cur_d      = cur_q;
      mode_d     = mode_q;
      ad_clk_d   = ad_clk;
      wr_idx_d   = wr_idx_q;
      rd_idx_d   = rd_idx_q;
      byte_sel_d = byte_sel_q;
      csum_d     = csum_q;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
      buf_we     = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               mode_d     = mode;
               wr_idx_d   = '0;
               rd_idx_d   = '0;
               byte_sel_d = 1'b0;
               csum_d     = '0;
               state_d    = CAPTURE;
            end
         end

         CAPTURE: begin
            if (!start) begin
               state_d = IDLE;
            end else if (strobe_edge) begin
               buf_we   = 1'b1;
               wr_idx_d = wr_idx_q + IW'(1);
               if (wr_idx_q == IW'(DEPTH - 1)) begin
                  tx_data_d = HDR_BYTE;
                  state_d   = HDR;
               end
            end
         end

         HDR, LEN0, LEN1, DATA, CSUM: begin
            if (!tx_busy) begin
               tx_start_d = 1'b1;
               cur_d      = state_q;
               state_d    = WAIT_HI;
               if (state_q inside {LEN0, LEN1, DATA}) begin
                  csum_d = csum_q ^ tx_data_q;
               end
               if (state_q == DATA) begin
                  if (byte_sel_q == 1'(BPS - 1)) begin
                     byte_sel_d = 1'b0;
                     rd_idx_d   = rd_idx_q + IW'(1);
                  end else begin
                     byte_sel_d = 1'b1;
                  end
               end
            end
         end

         WAIT_HI: begin
            if (tx_busy) begin
               state_d = WAIT_LO;
            end
         end

         WAIT_LO: begin
            if (!tx_busy) begin
               case (cur_q)
                  HDR: begin
                     tx_data_d = LEN[7:0];
                     state_d   = LEN0;
                  end
                  LEN0: begin
                     tx_data_d = LEN[15:8];
                     state_d   = LEN1;
                  end
                  LEN1: begin
                     tx_data_d = sample_byte;
                     state_d   = DATA;
                  end
                  DATA: begin
                     if (rd_idx_q == '0 && !byte_sel_q) begin
                        tx_data_d = csum_q;
                        state_d   = CSUM;
                     end else begin
                        tx_data_d = sample_byte;
                        state_d   = DATA;
                     end
                  end
                  default: begin
                     state_d = DONE;
                  end
               endcase
            end
         end

         DONE: begin
            if (!start) begin
               state_d = IDLE;
            end else if (mode_q) begin
               wr_idx_d   = '0;
               rd_idx_d   = '0;
               byte_sel_d = 1'b0;
               csum_d     = '0;
               state_d    = CAPTURE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers. Reset drops any tx_start in flight.
   always_ff @(posedge sysclk) begin
      if (rst) begin
         state_q    <= IDLE;
         cur_q      <= IDLE;
         mode_q     <= 1'b0;
         ad_clk_q   <= 1'b0;
         wr_idx_q   <= '0;
         rd_idx_q   <= '0;
         byte_sel_q <= 1'b0;
         csum_q     <= '0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_q      <= cur_d;
         mode_q     <= mode_d;
         ad_clk_q   <= ad_clk_d;
         wr_idx_q   <= wr_idx_d;
         rd_idx_q   <= rd_idx_d;
         byte_sel_q <= byte_sel_d;
         csum_q     <= csum_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
      end
   end

   assign tx_data  = tx_data_q;
   assign tx_start = tx_start_q;
   assign ready    = (state_q == DONE);
   assign busy     = (state_q != IDLE) && (state_q != DONE);

endmodule

// File: doc/adc_frame_streamer.md
# adc_frame_streamer

Parametrised ADC capture-and-stream engine, the successor to the single-channel fixed 32-sample reader. It captures DEPTH samples of SAMPLE_W bits on each rising edge of the divider's sample strobe into an internal buffer. It then transmits them to the host as a framed byte stream with length and checksum through the existing uart transmitter. It adds continuous mode, abort on start deassertion, and a busy indication.

## Interface
- SAMPLE_W, 12: ADC sample width, 1..16. Bytes per sample BPS = 1 if SAMPLE_W ≤ 8, else 2.
- DEPTH, 32: samples per frame, power of two, 2..1024.
- HDR_BYTE, 8'hA5: frame start byte.
- sysclk  in  1  single clock. All logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level. High arms and holds a capture run.
- mode  in  1  0 = single-shot, 1 = continuous. Sampled on leaving IDLE.
- ad_clk  in  1  sample strobe from divider, synchronous to sysclk.
- data_ad  in  SAMPLE_W  ADC result, valid at an ad_clk rising edge.
- tx_data  out  8  byte to uart din.
- tx_start  out  1  one-cycle write pulse to uart wr_en.
- tx_busy  in  1  uart busy.
- ready  out  1  frame complete.
- busy  out  1  high in any state except IDLE and DONE.

## Operation
- Reset: state IDLE. tx_data = 0, tx_start = 0, ready = 0, busy = 0. Sample counter, byte counter and checksum are 0.
- Strobe edge detection: an edge is registered when ad_clk_q = 0 and ad_clk = 1. ad_clk_q resets to 0.
- IDLE: when start = 1, latch mode, clear the counters, and go to CAPTURE.
- CAPTURE: on each edge, write data_ad to buffer[wr_idx] and increment wr_idx.
  - Writing index DEPTH-1 goes to HDR.
  - start = 0 goes to IDLE (abort). Nothing is transmitted.
- Frame byte order: HDR_BYTE, DEPTH[7:0], DEPTH[15:8], then each sample low byte then high byte (high byte only if BPS = 2, bits above SAMPLE_W zero), then CSUM.
  - CSUM = XOR of every byte after HDR_BYTE, excluding CSUM itself.
  - Total bytes = 4 + DEPTH·BPS.
- Send sub-FSM for each byte (states HDR, LEN0, LEN1, DATA, CSUM):
  - Load tx_data.
  - When tx_busy = 0, pulse tx_start for one cycle and go to WAIT_HI.
  - WAIT_HI: wait for tx_busy = 1.
  - WAIT_LO: wait for tx_busy = 0, then advance to the next byte state.
  - DATA loops rd_idx 0..DEPTH-1 and the byte select 0..BPS-1.
- start deasserted during transmission does not abort. The frame always completes.
- DONE behaviour:
  - Single-shot: ready = 1 holds until start = 0, then IDLE with ready = 0.
  - Continuous with start = 1: ready pulses for one cycle and the block re-enters CAPTURE with cleared counters.
  - Continuous with start = 0: IDLE.
- Strobe edges during transmission or DONE are ignored. No samples are buffered for the next frame.
- rst in any state returns to IDLE next cycle. A tx_start in flight is dropped. The uart may finish its current byte.

## Timing
- The buffer write happens in the same cycle the edge is detected (ad_clk high, ad_clk_q low).
- Last sample edge to HDR: 1 cycle. First tx_start: 2 cycles after the last edge if tx_busy = 0.
- tx_data is stable from the cycle before tx_start until WAIT_LO exits.
- tx_start is never asserted while tx_busy = 1 or in two consecutive cycles.
- Inter-byte gap: 1 cycle after tx_busy falls.
- ready rises the cycle after CSUM's WAIT_LO exits.

## Structure
- Shared package holds:
  - state encoding constants (IDLE, CAPTURE, HDR, LEN0, LEN1, DATA, CSUM, WAIT_HI, WAIT_LO, DONE);
  - the HDR_BYTE default;
  - the BPS derivation function;
  - the index width function clog2(DEPTH).
- One sub-module: sample_buffer, a simple dual-port RAM DEPTH×SAMPLE_W with synchronous write and registered read. DATA prefetches rd_idx one cycle ahead.
- The uart and divider stay outside the block. The top level wires them.

## Test plan
- DEPTH = 4, SAMPLE_W = 12, single-shot; samples 0x123, 0x456, 0x789, 0xABC, uart model busy 10 cycles per byte. Required bytes: A5 04 00 23 01 56 04 89 07 BC 0A 4C, then ready = 1 until start drops.
- SAMPLE_W = 8, DEPTH = 2; samples 0xFF, 0x01. Required bytes: A5 02 00 FF 01 FC (one byte per sample).
- Abort: start drops after 2 of 4 edges. Required: IDLE, no tx_start ever, ready = 0, busy = 0.
- Continuous mode, start held, 3 frames. Required: 3 complete frames, ready pulses exactly one cycle each, edges during transmission not captured.
- rst during DATA with tx_busy = 1. Required: next cycle all outputs are 0 and state is IDLE. A new start produces a correct full frame.
- Handshake checker on all tests: tx_start only when tx_busy = 0, single-cycle, and tx_data unchanged until tx_busy falls.
